// File: rtl/signal_debouncer.sv
// signal_debouncer: synchronizer plus stability-count FSM that turns a raw asynchronous input into a clean level.
// The optional rejected-transition counter (glitch_cnt) is built only when DEBOUNCE_GLITCH_CNT_EN is defined.
module signal_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal,
    output logic                clean,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [SYNC_STAGES-2:0] sync;
    logic s;
    logic abort;
    // The FSM evaluates the value entering the last synchronizer stage, so its own state register is that stage.
    assign s = sync[SYNC_STAGES-2];
    assign abort = (state == WAIT_H && !s) || (state == WAIT_L && s);
    // Leading synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync[0] <= signal;
            for (int i = 1; i < SYNC_STAGES - 1; i++) sync[i] <= sync[i-1];
        end
    end
    // Stability-count FSM with registered clean/busy; an abort always beats the threshold transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            clean <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                LOW: if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state <= HIGH;
                        clean <= 1'b1;
                    end else begin
                        state <= WAIT_H;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end
                WAIT_H: if (!s) begin
                    state <= LOW;
                    busy  <= 1'b0;
                end else if (cnt == LAST) begin
                    state <= HIGH;
                    clean <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HIGH: if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state <= LOW;
                        clean <= 1'b0;
                    end else begin
                        state <= WAIT_L;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end
                WAIT_L: if (s) begin
                    state <= HIGH;
                    busy  <= 1'b0;
                end else if (cnt == LAST) begin
                    state <= LOW;
                    clean <= 1'b0;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= LOW;
                    clean <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturating count of aborted qualifications; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) glitch_cnt <= '0;
        else if (abort && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + 1'b1;
    end
`else
    // GLITCH_W only sizes the optional counter; tie it off here.
    logic unused_cfg;
    assign unused_cfg = ^{GLITCH_W, abort};
`endif
endmodule

// File: tb/tb_signal_debouncer.sv
// tb_signal_debouncer: scoreboard bench for signal_debouncer (default, fast and narrow-counter configurations).
module tb_signal_debouncer;
    localparam int SYNC  = 2;
    localparam int LAT   = 5;
    localparam int LAT1  = 3;
    typedef struct {logic c; logic b;} exp_t;
    logic clk = 1'b0;
    logic rst;
    logic signal;
    logic c0, b0, c1, b1, c2, b2;
    exp_t q[$];
    exp_t e;
    int n = 0;
    int fails = 0;
    int exp_g0 = 0;
    int exp_g2 = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] g0, g1;
    logic [1:0] g2;
`endif
    always #5 clk = ~clk;
    signal_debouncer dut0 (
        .clk(clk), .rst(rst), .signal(signal), .clean(c0), .busy(b0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(g0)
`endif
    );
    signal_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .signal(signal), .clean(c1), .busy(b1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(g1)
`endif
    );
    signal_debouncer #(.GLITCH_W(2)) dut2 (
        .clk(clk), .rst(rst), .signal(signal), .clean(c2), .busy(b2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(g2)
`endif
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        signal = 1'b0;
        for (int k = 1; k <= 2; k++) q.push_back('{c: 1'b0, b: 1'b0});
        for (int k = 1; k <= 2; k++) begin
            tick();
            e = q.pop_front();
            n++;
            if ({c0, b0, c1, b1, c2, b2} !== {3{e.c, e.b}}) begin
                fails++;
                $display("FAIL reset edge %0d: clean/busy d0=%b%b d1=%b%b d2=%b%b, expected %b%b", k, c0, b0, c1, b1, c2, b2, e.c, e.b);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            n++;
            if (g0 !== 8'd0 || g2 !== 2'd0) begin
                fails++;
                $display("FAIL reset glitch_cnt: d0=%0d d2=%0d, expected 0", g0, g2);
            end
`endif
        end
        rst = 1'b0;
        repeat (4) tick();
    endtask
    task automatic test_rise_fall;
        signal = 1'b1;
        for (int k = 1; k <= 8; k++) q.push_back('{c: k >= LAT, b: k >= SYNC && k < LAT});
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = q.pop_front();
            n++;
            if (c0 !== e.c || b0 !== e.b) begin
                fails++;
                $display("FAIL rise edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c0, b0, e.c, e.b);
            end
        end
        signal = 1'b0;
        for (int k = 1; k <= 8; k++) q.push_back('{c: k < LAT, b: k >= SYNC && k < LAT});
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = q.pop_front();
            n++;
            if (c0 !== e.c || b0 !== e.b) begin
                fails++;
                $display("FAIL fall edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c0, b0, e.c, e.b);
            end
        end
    endtask
    task automatic test_glitch_high;
        for (int k = 1; k <= 8; k++) q.push_back('{c: 1'b0, b: k == 2 || k == 3});
        for (int k = 1; k <= 8; k++) begin
            signal = (k <= 2);
            tick();
            e = q.pop_front();
            n++;
            if (c0 !== e.c || b0 !== e.b) begin
                fails++;
                $display("FAIL glitch_high edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c0, b0, e.c, e.b);
            end
        end
        exp_g0++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n++;
        if (g0 !== 8'(exp_g0)) begin
            fails++;
            $display("FAIL glitch_high count: glitch_cnt=%0d, expected %0d", g0, exp_g0);
        end
`endif
    endtask
    task automatic test_glitch_low;
        signal = 1'b1;
        repeat (8) tick();
        n++;
        if (c0 !== 1'b1) begin
            fails++;
            $display("FAIL glitch_low setup: clean=%b, expected 1", c0);
        end
        for (int k = 1; k <= 8; k++) q.push_back('{c: 1'b1, b: k == 2 || k == 3});
        for (int k = 1; k <= 8; k++) begin
            signal = (k > 2);
            tick();
            e = q.pop_front();
            n++;
            if (c0 !== e.c || b0 !== e.b) begin
                fails++;
                $display("FAIL glitch_low edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c0, b0, e.c, e.b);
            end
        end
        exp_g0++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n++;
        if (g0 !== 8'(exp_g0)) begin
            fails++;
            $display("FAIL glitch_low count: glitch_cnt=%0d, expected %0d", g0, exp_g0);
        end
`endif
        signal = 1'b0;
        repeat (8) tick();
        n++;
        if (c0 !== 1'b0 || b0 !== 1'b0) begin
            fails++;
            $display("FAIL glitch_low settle: clean=%b busy=%b, expected 0 0", c0, b0);
        end
    endtask
    task automatic test_reset_mid;
        signal = 1'b1;
        for (int k = 1; k <= 3; k++) q.push_back('{c: 1'b0, b: k >= SYNC});
        q.push_back('{c: 1'b0, b: 1'b0});
        for (int k = 1; k <= 6; k++) q.push_back('{c: k >= LAT, b: k >= SYNC && k < LAT});
        for (int k = 1; k <= 10; k++) begin
            rst = (k == 4);
            tick();
            e = q.pop_front();
            n++;
            if (c0 !== e.c || b0 !== e.b) begin
                fails++;
                $display("FAIL reset_mid edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c0, b0, e.c, e.b);
            end
        end
        rst = 1'b0;
        exp_g0 = 0;
        exp_g2 = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n++;
        if (g0 !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid count: glitch_cnt=%0d, expected 0", g0);
        end
`endif
        signal = 1'b0;
        repeat (8) tick();
    endtask
    task automatic test_fast;
        rst = 1'b1;
        signal = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        for (int k = 1; k <= 6; k++) q.push_back('{c: k >= LAT1, b: 1'b0});
        for (int k = 1; k <= 6; k++) q.push_back('{c: k < LAT1, b: 1'b0});
        for (int k = 1; k <= 6; k++) q.push_back('{c: k == LAT1, b: 1'b0});
        for (int k = 1; k <= 18; k++) begin
            signal = (k <= 6) || (k == 13);
            tick();
            e = q.pop_front();
            n++;
            if (c1 !== e.c || b1 !== e.b) begin
                fails++;
                $display("FAIL fast step %0d: clean=%b busy=%b, expected clean=%b busy=%b", k, c1, b1, e.c, e.b);
            end
        end
    endtask
    task automatic test_saturate;
        rst = 1'b1;
        signal = 1'b0;
        tick();
        rst = 1'b0;
        exp_g0 = 0;
        exp_g2 = 0;
        repeat (3) tick();
        for (int p = 1; p <= 5; p++) begin
            for (int k = 1; k <= 6; k++) q.push_back('{c: 1'b0, b: k == 2 || k == 3});
            for (int k = 1; k <= 6; k++) begin
                signal = (k <= 2);
                tick();
                e = q.pop_front();
                n++;
                if (c2 !== e.c || b2 !== e.b) begin
                    fails++;
                    $display("FAIL saturate pulse %0d edge %0d: clean=%b busy=%b, expected clean=%b busy=%b", p, k, c2, b2, e.c, e.b);
                end
            end
            exp_g0++;
            exp_g2 = (exp_g2 < 3) ? exp_g2 + 1 : 3;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            n++;
            if (g2 !== 2'(exp_g2) || g0 !== 8'(exp_g0)) begin
                fails++;
                $display("FAIL saturate count %0d: narrow=%0d wide=%0d, expected narrow=%0d wide=%0d", p, g2, g0, exp_g2, exp_g0);
            end
`endif
        end
    endtask
    initial begin
        test_reset();
        test_rise_fall();
        test_glitch_high();
        test_glitch_low();
        test_reset_mid();
        test_fast();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n, fails);
        $finish;
    end
endmodule
